// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller: colour and FSM
// state encodings plus the LFSR definition.
package simon_pkg;

  typedef enum logic [1:0] {
    COL_B = 2'd0,
    COL_G = 2'd1,
    COL_R = 2'd2,
    COL_Y = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    ROUND_DONE,
    WIN,
    LOSE
  } state_t;

  // Feedback taps b15, b13, b12, b10 of the 16-bit Fibonacci LFSR.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_game_ctrl_lfsr.sv
// 16-bit left-shifting Fibonacci LFSR; a zero seed is replaced by the
// default seed so the register can never lock up at all-zeros.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value_q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      value_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game sequencer: generates a colour sequence, plays growing rounds
// on the LED and checks presses. Optional input timeout: SIMON_TIMEOUT_EN.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 8,
  parameter int TICK_DIV      = 25000000,
  parameter int TIMEOUT_TICKS = 250000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic        btn_valid,
  input  logic [1:0]  btn_color,
  output logic        led_on,
  output logic [1:0]  led_color,
  output logic        await_input,
  output logic [3:0]  round_len,
  output logic [3:0]  score,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   last_q;     // round_len - 1
  logic [TW-1:0]   tick_q;
  logic [3:0]      score_q;
  color_t          seq_q [MAX_LEN];
  logic [15:0]     lfsr_value;
  logic            timeout_hit;
  logic            idx_at_end;
  logic            tick_done;
  logic            new_game;

  assign new_game   = start && (state_q == IDLE || state_q == WIN || state_q == LOSE);
  assign idx_at_end = (idx_q == last_q);
  assign tick_done  = (tick_q == TW'(TICK_DIV - 1));

  simon_lfsr u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .load   (new_game),
    .seed   (seed),
    .step   (state_q == GEN),
    .value  (lfsr_value)
  );

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_value[15:2];

  // NOTE: the sequence memory has no reset; it is always rewritten in GEN before it is read.
  always_ff @(posedge clk) begin
    if (resetn && state_q == GEN) begin
      seq_q[idx_q] <= color_t'(lfsr_value[1:0]);
    end
  end

`ifdef SIMON_TIMEOUT_EN
  localparam int WW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  logic [WW-1:0] wait_q;

  always_ff @(posedge clk) begin
    if (!resetn || state_q != INPUT || btn_valid) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + WW'(1);
    end
  end

  assign timeout_hit = (wait_q == WW'(TIMEOUT_TICKS - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      tick_q  <= '0;
      score_q <= '0;
    end else begin
      case (state_q)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state_q <= GEN;
            idx_q   <= '0;
            last_q  <= '0;
            tick_q  <= '0;
            score_q <= '0;
          end
        end
        GEN: begin
          if (idx_q == IW'(MAX_LEN - 1)) begin
            state_q <= SHOW_ON;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        SHOW_ON: begin
          if (tick_done) begin
            state_q <= SHOW_OFF;
            tick_q  <= '0;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        SHOW_OFF: begin
          if (tick_done) begin
            tick_q <= '0;
            if (idx_at_end) begin
              state_q <= INPUT;
              idx_q   <= '0;
            end else begin
              state_q <= SHOW_ON;
              idx_q   <= idx_q + IW'(1);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        INPUT: begin
          // A press in the same cycle as the timeout still counts.
          if (btn_valid) begin
            if (btn_color == seq_q[idx_q]) begin
              if (idx_at_end) begin
                state_q <= ROUND_DONE;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else begin
              state_q <= LOSE;
            end
          end else if (timeout_hit) begin
            state_q <= LOSE;
          end
        end
        ROUND_DONE: begin
          score_q <= 4'(last_q) + 4'd1;
          if (last_q == IW'(MAX_LEN - 1)) begin
            state_q <= WIN;
          end else begin
            last_q  <= last_q + IW'(1);
            idx_q   <= '0;
            state_q <= SHOW_ON;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // With MAX_LEN=16 the final length/score of 16 reads as 0 on the 4-bit ports.
  assign led_on      = (state_q == SHOW_ON);
  assign led_color   = led_on ? seq_q[idx_q] : COL_B;
  assign await_input = (state_q == INPUT);
  assign round_len   = 4'(last_q) + 4'd1;
  assign score       = score_q;
  assign busy        = (state_q == GEN) || (state_q == SHOW_ON) || (state_q == SHOW_OFF)
                    || (state_q == INPUT) || (state_q == ROUND_DONE);
  assign win         = (state_q == WIN);
  assign lose        = (state_q == LOSE);

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl with MAX_LEN=3, TICK_DIV=2, TIMEOUT_TICKS=5.
module tb_simon_game_ctrl;

  localparam int MAX_LEN       = 3;
  localparam int TICK_DIV      = 2;
  localparam int TIMEOUT_TICKS = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] seed;
  logic        btn_valid;
  logic [1:0]  btn_color;
  logic        led_on;
  logic [1:0]  led_color;
  logic        await_input;
  logic [3:0]  round_len;
  logic [3:0]  score;
  logic        busy;
  logic        win;
  logic        lose;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simon_game_ctrl #(
    .MAX_LEN       (MAX_LEN),
    .TICK_DIV      (TICK_DIV),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .seed        (seed),
    .btn_valid   (btn_valid),
    .btn_color   (btn_color),
    .led_on      (led_on),
    .led_color   (led_color),
    .await_input (await_input),
    .round_len   (round_len),
    .score       (score),
    .busy        (busy),
    .win         (win),
    .lose        (lose)
  );

  typedef struct {
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_color;
    logic       led_on;
    logic [1:0] led_color;
    logic       await_i;
    logic [3:0] rl;
    logic [3:0] sc;
    logic       busy;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, input logic bv, input logic [1:0] bc,
                             input logic lo, input logic [1:0] lc, input logic aw,
                             input logic [3:0] rl, input logic [3:0] sc,
                             input logic bz, input logic wn, input logic ls);
    vec_t r;
    r.start = st; r.btn_valid = bv; r.btn_color = bc;
    r.led_on = lo; r.led_color = lc; r.await_i = aw;
    r.rl = rl; r.sc = sc; r.busy = bz; r.win = wn; r.lose = ls;
    return r;
  endfunction

  // Reference LFSR: colour n is bits [1:0] after n shifts of the (substituted) seed.
  function automatic logic [1:0] ref_color(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = (s == 16'h0000) ? 16'hACE1 : s;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    return r[1:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    check({tag, ".led_on"},      led_on,      e.led_on);
    check({tag, ".led_color"},   led_color,   e.led_color);
    check({tag, ".await_input"}, await_input, e.await_i);
    check({tag, ".round_len"},   round_len,   e.rl);
    check({tag, ".score"},       score,       e.sc);
    check({tag, ".busy"},        busy,        e.busy);
    check({tag, ".win"},         win,         e.win);
    check({tag, ".lose"},        lose,        e.lose);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] s);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    tick();
    btn_valid = 1'b0;
  endtask

  task automatic wait_await(input string tag);
    int n = 0;
    while (await_input !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".await_reached"}, await_input, 1'b1);
  endtask

  task automatic wait_led(input string tag, input logic [1:0] exp);
    int n = 0;
    while (led_on !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".led_on"}, led_on, 1'b1);
    check({tag, ".led_color"}, led_color, exp);
    n = 0;
    while (led_on === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c0, c1, c2, a0, a1;
    c0 = ref_color(16'h0001, 0);
    c1 = ref_color(16'h0001, 1);
    c2 = ref_color(16'h0001, 2);
    a0 = ref_color(16'h0000, 0);
    a1 = ref_color(16'h0000, 1);

    // Full game with seed 1: rows are {inputs this cycle, outputs after the edge}.
    // Ignored start/btn pulses are mixed into GEN and playback rows.
    tbl.push_back(v(1,0,0,  0,0, 0, 1,0, 1,0,0));
    tbl.push_back(v(0,1,c0, 0,0, 0, 1,0, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 1,0, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c0,0, 1,0, 1,0,0));
    tbl.push_back(v(1,0,0,  1,c0,0, 1,0, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 1,0, 1,0,0));
    tbl.push_back(v(0,1,c0, 0,0, 0, 1,0, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 1, 1,0, 1,0,0));
    tbl.push_back(v(0,1,c0, 0,0, 0, 1,0, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c0,0, 2,1, 1,0,0));
    tbl.push_back(v(0,1,c1, 1,c0,0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 2,1, 1,0,0));
    tbl.push_back(v(1,1,c0, 0,0, 0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c1,0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c1,0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 1, 2,1, 1,0,0));
    tbl.push_back(v(0,1,c0, 0,0, 1, 2,1, 1,0,0));
    tbl.push_back(v(0,1,c1, 0,0, 0, 2,1, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c0,0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c0,0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(1,1,c1, 1,c1,0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c1,0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(0,1,c2, 0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c2,0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  1,c2,0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 1, 3,2, 1,0,0));
    tbl.push_back(v(0,1,c0, 0,0, 1, 3,2, 1,0,0));
    tbl.push_back(v(0,1,c1, 0,0, 1, 3,2, 1,0,0));
    tbl.push_back(v(0,1,c2, 0,0, 0, 3,2, 1,0,0));
    tbl.push_back(v(0,0,0,  0,0, 0, 3,3, 0,1,0));
    tbl.push_back(v(0,1,c0, 0,0, 0, 3,3, 0,1,0));

    resetn    = 1'b0;
    start     = 1'b0;
    seed      = 16'h0001;
    btn_valid = 1'b0;
    btn_color = 2'd0;
    @(negedge clk);
    tick();
    tick();
    check_outs("reset", v(0,0,0, 0,0,0, 1,0, 0,0,0));
    resetn = 1'b1;
    tick();
    check_outs("idle", v(0,0,0, 0,0,0, 1,0, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      start     = tbl[i].start;
      btn_valid = tbl[i].btn_valid;
      btn_color = tbl[i].btn_color;
      tick();
      start     = 1'b0;
      btn_valid = 1'b0;
      check_outs($sformatf("vec%0d", i), tbl[i]);
    end

    // Wrong second press in round 2.
    do_start(16'h0001);
    wait_await("s3r1");
    press(c0);
    wait_await("s3r2");
    press(c0);
    press(c1 ^ 2'd1);
    check_outs("s3.lose", v(0,0,0, 0,0,0, 2,1, 0,0,1));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("s3.led_off%0d", k), led_on, 1'b0);
      check($sformatf("s3.lose_held%0d", k), lose, 1'b1);
    end

    // Reset mid-INPUT, then a zero seed behaves as 16'hACE1.
    do_start(16'h0001);
    wait_await("s5");
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_outs("s5.reset", v(0,0,0, 0,0,0, 1,0, 0,0,0));
    do_start(16'h0000);
    wait_led("s5.r1e0", a0);
    wait_await("s5r1");
    press(a0);
    wait_led("s5.r2e0", a0);
    wait_led("s5.r2e1", a1);
    wait_await("s5r2");
    check("s5.round_len", round_len, 4'd2);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    do_start(16'h0001);
    wait_await("s6");
`ifdef SIMON_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT_TICKS; k++) begin
      tick();
      check($sformatf("s6.no_lose%0d", k), lose, 1'b0);
    end
    tick();
    check("s6.timeout_lose", lose, 1'b1);
    check("s6.timeout_busy", busy, 1'b0);
    do_start(16'h0001);
    wait_await("s6b");
    repeat (TIMEOUT_TICKS - 1) tick();
    press(c0);
    check("s6b.lose", lose, 1'b0);
    check("s6b.busy", busy, 1'b1);
    tick();
    check("s6b.score", score, 4'd1);
    check("s6b.lose2", lose, 1'b0);
`else
    repeat (20) tick();
    check("s6.still_waiting", await_input, 1'b1);
    check("s6.no_lose", lose, 1'b0);
    check("s6.busy", busy, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
